// File: rtl/cbm2_keyboard.sv
// cbm2_keyboard: PS/2 event queue + paced 16x6 CBM-II key matrix feeding TPI2 port C
//   clk_sys  in   system clock
//   reset    in   synchronous, active-high
//   ps2_key  in   [10] toggle strobe, [9] pressed, [8] extended (E0), [7:0] scancode
//   kbd_out  in   {tpi2_pao, tpi2_pbo}; row r driven when bit r is 0
//   kbd_in   out  to tpi2 pc_in[5:0]; column c reads 0 when pressed in a driven row
//   overflow out  sticky flag: an event was dropped on a full queue
//   CBM2_KBD_GHOST_EN: when defined, the read path emulates one-level ghosting
module cbm2_keyboard #(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 65536
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [15:0] kbd_out,
  output logic [5:0]  kbd_in,
  output logic        overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(HOLD_CYCLES) + 1;
  typedef enum logic [1:0] {IDLE, LOOKUP, APPLY, HOLD} state_t;
  state_t state, state_nx;
  logic last_tog;
  logic [9:0] fifo [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [9:0] ev;
  logic km_hit, km_press;
  logic [3:0] km_row;
  logic [2:0] km_col;
  logic hit;
  logic [3:0] row;
  logic [2:0] col;
  logic [CW-1:0] cnt;
  logic [15:0][5:0] matrix;
  logic [5:0] dcols, read;
  logic tog, empty, full, pop, push;
  assign tog   = ps2_key[10] ^ last_tog;
  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop   = (state == IDLE) && !empty;
  // a full queue still accepts the new event when a slot frees up this same cycle
  assign push  = tog && (!full || pop);
  // {ext,code} -> {hit,row,col}; columns 6/7 are never produced
  always_comb begin
    {hit, row, col} = 8'h00;
    case (ev[8:0])
      9'h01C: {hit, row, col} = {1'b1, 4'd4,  3'd2};
      9'h01B: {hit, row, col} = {1'b1, 4'd4,  3'd4};
      9'h029: {hit, row, col} = {1'b1, 4'd15, 3'd4};
      9'h012: {hit, row, col} = {1'b1, 4'd8,  3'd4};
      9'h05A: {hit, row, col} = {1'b1, 4'd6,  3'd5};
      9'h175: {hit, row, col} = {1'b1, 4'd10, 3'd4};
      default: {hit, row, col} = 8'h00;
    endcase
  end
  // dcols: every column holding a pressed key in some driven row
  always_comb begin
    dcols = '0;
    for (int r = 0; r < 16; r++) dcols |= kbd_out[r] ? 6'h00 : matrix[r];
`ifdef CBM2_KBD_GHOST_EN
    read = '0;
    for (int r = 0; r < 16; r++) read |= |(matrix[r] & dcols) ? matrix[r] : 6'h00;
`else
    read = dcols;
`endif
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = empty ? IDLE : LOOKUP;
      LOOKUP:  state_nx = APPLY;
      APPLY:   state_nx = km_hit ? HOLD : IDLE;
      HOLD:    state_nx = cnt == '0 ? IDLE : HOLD;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_sys) state <= reset ? IDLE : state_nx;
  always_ff @(posedge clk_sys) if (push) fifo[wr_ptr[AW-1:0]] <= ps2_key[9:0];
  always_ff @(posedge clk_sys) begin
    last_tog <= ps2_key[10];
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      ev       <= '0;
      {km_hit, km_press, km_row, km_col} <= '0;
      cnt      <= '0;
      matrix   <= '0;
      kbd_in   <= 6'h3F;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (tog && !push) overflow <= 1'b1;
      if (pop) begin
        ev     <= fifo[rd_ptr[AW-1:0]];
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (state == LOOKUP) {km_hit, km_press, km_row, km_col} <= {hit, ev[9], row, col};
      if (state == APPLY && km_hit) begin
        matrix[km_row][km_col] <= km_press;
        cnt <= CW'(HOLD_CYCLES - 1);
      end
      if (state == HOLD && cnt != '0) cnt <= cnt - 1'b1;
      kbd_in <= ~read;
    end
  end
endmodule
